half_subtractor: RTL and testbench



---
 rtl/half_sub_pkg.sv | 24 ++
 rtl/half_subtractor_if.sv | 36 +++
 rtl/hs_cell.sv | 21 ++
 rtl/half_subtractor.sv | 62 ++++++
 tb/tb_half_subtractor.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/half_sub_pkg.sv
// ---------------------------------------------------------------------------
// half_sub_pkg
// Shared definitions for the half subtractor family.
//   HS_MAX_WIDTH : largest supported lane count for lane-parallel users.
//   hs_diff()    : 1-bit difference, a ^ b.
//   hs_borrow()  : 1-bit borrow-out, ~a & b.
// The equations live here so that ripple/borrow-chain subtractors and
// comparators elsewhere in the datapath reuse exactly the same logic.
// ---------------------------------------------------------------------------
package half_sub_pkg;

  localparam int HS_MAX_WIDTH = 64;

  // Difference bit of a - b for a single lane.
  function automatic logic hs_diff(input logic a, input logic b);
    return a ^ b;
  endfunction

  // Borrow is needed only when subtracting 1 from 0.
  function automatic logic hs_borrow(input logic a, input logic b);
    return ~a & b;
  endfunction

endpackage

// File: rtl/half_subtractor_if.sv
// ---------------------------------------------------------------------------
// half_subtractor_if
// Groups the operand inputs and both result paths of the half subtractor.
//   in_valid, a, b          : operands plus qualifier for the registered path
//   diff, borrow            : combinational per-lane results
//   out_valid, diff_q,
//   borrow_q, borrow_any_q  : registered results
// Modports:
//   master : the producer/consumer driving operands and reading results
//   slave  : the half_subtractor itself
// ---------------------------------------------------------------------------
interface half_subtractor_if #(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow;
  logic             out_valid;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic             borrow_any_q;

  modport master (
    output in_valid, a, b,
    input  diff, borrow, out_valid, diff_q, borrow_q, borrow_any_q
  );

  modport slave (
    input  in_valid, a, b,
    output diff, borrow, out_valid, diff_q, borrow_q, borrow_any_q
  );

endinterface

// File: rtl/hs_cell.sv
// ---------------------------------------------------------------------------
// hs_cell
// One-bit combinational half subtractor cell.
//   a      : minuend bit
//   b      : subtrahend bit
//   diff   : a ^ b
//   borrow : ~a & b
// ---------------------------------------------------------------------------
module hs_cell
  import half_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = hs_diff(a, b);
  assign borrow = hs_borrow(a, b);

endmodule

// File: rtl/half_subtractor.sv
// ---------------------------------------------------------------------------
// half_subtractor
// Lane-parallel 1-bit half subtractor with an optional registered copy.
//   clk   : rising-edge clock for the registered path
//   rst_n : asynchronous active-low reset of the registered path
//   bus   : half_subtractor_if slave port
//           in_valid/a/b in; diff/borrow combinational out;
//           out_valid/diff_q/borrow_q/borrow_any_q registered out
// Lanes are independent: no borrow ripples between lanes. The combinational
// outputs ignore clk, rst_n and in_valid entirely.
// ---------------------------------------------------------------------------
module half_subtractor
  import half_sub_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  half_subtractor_if.slave        bus
);

  // Reject lane counts outside the supported range at elaboration time.
  if (WIDTH < 1 || WIDTH > HS_MAX_WIDTH) begin : g_width_check
    $error("half_subtractor: WIDTH out of range");
  end

  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] borrow_w;

  // One independent cell per lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    hs_cell u_cell (
      .a      (bus.a[i]),
      .b      (bus.b[i]),
      .diff   (diff_w[i]),
      .borrow (borrow_w[i])
    );
  end

  assign bus.diff   = diff_w;
  assign bus.borrow = borrow_w;

  // Output register stage. Results are captured only when in_valid is
  // sampled high; otherwise the data holds and out_valid drops so that a
  // consumer sees exactly one valid pulse per accepted operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.diff_q       <= '0;
      bus.borrow_q     <= '0;
      bus.borrow_any_q <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.diff_q       <= diff_w;
        bus.borrow_q     <= borrow_w;
        bus.borrow_any_q <= |borrow_w;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor.sv
// ---------------------------------------------------------------------------
// tb_half_subtractor
// Self-checking bench for half_subtractor at WIDTH = 1, 4 and 8.
// ---------------------------------------------------------------------------
module tb_half_subtractor;

  logic clk;
  logic rst_n;
  logic clkEn;

  int checkCount;
  int errorCount;

  half_subtractor_if #(.WIDTH(1)) bus1 ();
  half_subtractor_if #(.WIDTH(4)) bus4 ();
  half_subtractor_if #(.WIDTH(8)) bus8 ();

  half_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  half_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  half_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Clock is held still until clkEn is raised so the combinational path can
  // be exercised with no clock running.
  initial clk = 1'b0;
  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one operand set onto the selected instance just after a falling edge.
  task automatic applyStimulus(input int which, input logic v,
                               input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    case (which)
      1: begin bus1.in_valid = v; bus1.a = av[0];   bus1.b = bv[0];   end
      4: begin bus4.in_valid = v; bus4.a = av[3:0]; bus4.b = bv[3:0]; end
      default: begin bus8.in_valid = v; bus8.a = av; bus8.b = bv; end
    endcase
  endtask

  // Reference: per lane compute the integer a - b; a nonzero result means
  // the difference bit is 1, a negative one means a borrow was needed.
  function automatic logic [15:0] refSub(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] d;
    logic [7:0] br;
    int         s;
    for (int i = 0; i < 8; i++) begin
      s     = int'(av[i]) - int'(bv[i]);
      d[i]  = (s != 0);
      br[i] = (s < 0);
    end
    return {br, d};
  endfunction

  initial begin
    bit expD [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit expB [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ra, rb;
    logic        rv;
    logic [15:0] r;
    logic [7:0]  mDiffQ, mBorQ;
    logic        mAnyQ, mValid;

    checkCount = 0;
    errorCount = 0;
    clkEn = 1'b0;
    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;

    // Combinational truth table with no clock and reset held.
    for (int i = 0; i < 4; i++) begin
      bus1.a = i[1];
      bus1.b = i[0];
      #1;
      checkOutput("w1_diff_noclk",   bus1.diff,      expD[i]);
      checkOutput("w1_borrow_noclk", bus1.borrow,    expB[i]);
      checkOutput("w1_dq_rst",       bus1.diff_q,    0);
      checkOutput("w1_bq_rst",       bus1.borrow_q,  0);
      checkOutput("w1_ov_rst",       bus1.out_valid, 0);
      #1;
    end

    rst_n = 1'b1;
    clkEn = 1'b1;

    // WIDTH=1: single accepted operand, then hold.
    applyStimulus(1, 1'b1, 8'h00, 8'h01);
    @(posedge clk); #1;
    checkOutput("w1_dq",  bus1.diff_q,       1);
    checkOutput("w1_bq",  bus1.borrow_q,     1);
    checkOutput("w1_any", bus1.borrow_any_q, 1);
    checkOutput("w1_ov",  bus1.out_valid,    1);
    applyStimulus(1, 1'b0, 8'h01, 8'h01);
    @(posedge clk); #1;
    checkOutput("w1_ov_drop", bus1.out_valid, 0);
    checkOutput("w1_dq_hold", bus1.diff_q,    1);
    checkOutput("w1_bq_hold", bus1.borrow_q,  1);

    // WIDTH=4: mixed lanes.
    applyStimulus(4, 1'b1, 8'b1010, 8'b0110);
    #1;
    checkOutput("w4_diff",   bus4.diff,   4'b1100);
    checkOutput("w4_borrow", bus4.borrow, 4'b0100);
    @(posedge clk); #1;
    checkOutput("w4_dq",  bus4.diff_q,       4'b1100);
    checkOutput("w4_bq",  bus4.borrow_q,     4'b0100);
    checkOutput("w4_any", bus4.borrow_any_q, 1);
    checkOutput("w4_ov",  bus4.out_valid,    1);

    // WIDTH=4: equal operands give no difference and no borrow.
    applyStimulus(4, 1'b1, 8'b1111, 8'b1111);
    #1;
    checkOutput("w4eq_diff",   bus4.diff,   0);
    checkOutput("w4eq_borrow", bus4.borrow, 0);
    @(posedge clk); #1;
    checkOutput("w4eq_dq",  bus4.diff_q,       0);
    checkOutput("w4eq_any", bus4.borrow_any_q, 0);
    applyStimulus(4, 1'b0, 8'h0, 8'h0);

    // Asynchronous reset between clock edges while a result is held.
    applyStimulus(1, 1'b1, 8'h00, 8'h01);
    @(posedge clk); #1;
    checkOutput("ar_ov_pre", bus1.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_ov",     bus1.out_valid,    0);
    checkOutput("ar_dq",     bus1.diff_q,       0);
    checkOutput("ar_bq",     bus1.borrow_q,     0);
    checkOutput("ar_any",    bus1.borrow_any_q, 0);
    checkOutput("ar_diff_live",   bus1.diff,   1);
    checkOutput("ar_borrow_live", bus1.borrow, 1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ar_post_ov", bus1.out_valid, 0);
    checkOutput("ar_post_dq", bus1.diff_q,    0);
    @(posedge clk); #1;
    checkOutput("ar_post_ov2", bus1.out_valid, 0);
    applyStimulus(1, 1'b1, 8'h01, 8'h00);
    @(posedge clk); #1;
    checkOutput("ar_first_ov",  bus1.out_valid,    1);
    checkOutput("ar_first_dq",  bus1.diff_q,       1);
    checkOutput("ar_first_bq",  bus1.borrow_q,     0);
    checkOutput("ar_first_any", bus1.borrow_any_q, 0);
    applyStimulus(1, 1'b0, 8'h00, 8'h00);

    // Randomized WIDTH=8 stream against the reference model.
    mDiffQ = '0; mBorQ = '0; mAnyQ = 1'b0; mValid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rv = 1'($urandom_range(0, 1));
      applyStimulus(8, rv, ra, rb);
      r = refSub(ra, rb);
      #1;
      checkOutput("rnd_diff",   bus8.diff,   r[7:0]);
      checkOutput("rnd_borrow", bus8.borrow, r[15:8]);
      @(posedge clk); #1;
      mValid = rv;
      if (rv) begin
        mDiffQ = r[7:0];
        mBorQ  = r[15:8];
        mAnyQ  = (r[15:8] != 0);
      end
      checkOutput("rnd_ov",  bus8.out_valid,    mValid);
      checkOutput("rnd_dq",  bus8.diff_q,       mDiffQ);
      checkOutput("rnd_bq",  bus8.borrow_q,     mBorQ);
      checkOutput("rnd_any", bus8.borrow_any_q, mAnyQ);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
